// File: rtl/half_adder_pkg.sv
// Shared helpers for the registered half-adder: counter sizing and carry population count.
package half_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // Smallest r with 2**r >= n; used to size a counter that must reach WIDTH.
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single combinational half-adder lane.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/half_adder_reg.sv
// Registered lane-parallel half adder with carry population count and any-carry flag.
module half_adder_reg
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  localparam int unsigned CNT_W = clog2_w(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             any_carry
);

  logic [WIDTH-1:0]     sum_w;
  logic [WIDTH-1:0]     carry_w;
  logic [MAX_WIDTH-1:0] carry_ext;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (in1[i]),
      .b (in2[i]),
      .s (sum_w[i]),
      .c (carry_w[i])
    );
  end

  assign carry_ext = MAX_WIDTH'(carry_w);

  // Result registers load only on in_valid, so idle-cycle inputs (even X) never reach them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= '0;
      carry_cnt <= '0;
      any_carry <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_w;
        carry     <= carry_w;
        carry_cnt <= CNT_W'(popcount(carry_ext));
        any_carry <= |carry_w;
      end
    end
  end

endmodule

// File: tb/tb_half_adder_reg.sv
// Directed and random checks of half_adder_reg at WIDTH=1 and WIDTH=8.
module tb_half_adder_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       v1, a1, b1;
  logic       ov1, s1, c1, cnt1, any1;
  logic       v8;
  logic [7:0] a8, b8;
  logic       ov8, any8;
  logic [7:0] s8, c8;
  logic [3:0] cnt8;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  half_adder_reg #(.WIDTH(1)) u_w1 (
    .clk (clk), .rst_n (rst_n), .in_valid (v1), .in1 (a1), .in2 (b1),
    .out_valid (ov1), .sum (s1), .carry (c1), .carry_cnt (cnt1), .any_carry (any1)
  );

  half_adder_reg #(.WIDTH(8)) u_w8 (
    .clk (clk), .rst_n (rst_n), .in_valid (v8), .in1 (a8), .in2 (b8),
    .out_valid (ov8), .sum (s8), .carry (c8), .carry_cnt (cnt8), .any_carry (any8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic v, input logic s, input logic c,
                      input logic n, input logic a);
    chk({tag, ".ov"},  64'(ov1),  64'(v));
    chk({tag, ".sum"}, 64'(s1),   64'(s));
    chk({tag, ".car"}, 64'(c1),   64'(c));
    chk({tag, ".cnt"}, 64'(cnt1), 64'(n));
    chk({tag, ".any"}, 64'(any1), 64'(a));
  endtask

  task automatic chk8(input string tag, input logic v, input logic [7:0] s,
                      input logic [7:0] c, input logic [3:0] n, input logic a);
    chk({tag, ".ov"},  64'(ov8),  64'(v));
    chk({tag, ".sum"}, 64'(s8),   64'(s));
    chk({tag, ".car"}, 64'(c8),   64'(c));
    chk({tag, ".cnt"}, 64'(cnt8), 64'(n));
    chk({tag, ".any"}, 64'(any8), 64'(a));
  endtask

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec1_t;

  initial begin
    vec1_t      tbl[4];
    logic       ev;
    logic [7:0] es, ec;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0};

    // reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
    end
    chk1("rst_w1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk8("rst_w8", 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);

    v1 = 1'b0; v8 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk1("idle_w1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=1 truth table, back to back
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1; a1 = tbl[i].a; b1 = tbl[i].b;
      tick();
      chk1($sformatf("tt%0d", i), 1'b1, tbl[i].s, tbl[i].c, tbl[i].c, tbl[i].c);
    end

    // hold after a (1,1) capture while idle inputs wiggle
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    tick();
    chk1("hold_cap", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b0; a1 = 1'(i); b1 = 1'(i + 1);
      tick();
      chk1($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    a1 = 1'bx; b1 = 1'bx;
    tick();
    chk1("hold_x", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // WIDTH=8 lanes
    v8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
    tick();
    chk8("w8_f0cc", 1'b1, 8'h3C, 8'hC0, 4'd2, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF;
    tick();
    chk8("w8_ffff", 1'b1, 8'h00, 8'hFF, 4'd8, 1'b1);
    v8 = 1'b0; a8 = 'x; b8 = 'x;
    tick();
    chk8("w8_x", 1'b0, 8'h00, 8'hFF, 4'd8, 1'b1);

    // asynchronous reset between edges discards a capture
    v8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
    tick();
    chk8("mid_cap", 1'b1, 8'h00, 8'hAA, 4'd4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk8("mid_async", 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    v8 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk8("mid_post", 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);

    // random soak against an independent model
    ev = 1'b0; es = '0; ec = '0;
    for (int i = 0; i < 10000; i++) begin
      v8 = 1'($urandom_range(0, 3) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      ev = v8;
      if (v8) begin
        for (int k = 0; k < 8; k++) begin
          es[k] = (a8[k] != b8[k]);
          ec[k] = (a8[k] == 1'b1) && (b8[k] == 1'b1);
        end
      end
      tick();
      chk8("soak", ev, es, ec, 4'($countones(ec)), ec != 8'h00);
      chk("inv_any", 64'(any8), 64'(cnt8 != 4'd0));
      chk("inv_sc", 64'(s8 & c8), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
